// File: rtl/pio_word_serializer.sv
// Shifts the PIO output word MSB-first into an external 74HC595-style chain
// whenever the word changes, on a forced refresh, and once after reset.
module pio_word_serializer #(
  parameter int WIDTH   = 18,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_word,
  input  logic             force_update,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             busy,
  output logic [WIDTH-1:0] sent_word
);

  localparam int PW = $clog2(2*CLK_DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [PW-1:0] PH_LO_END = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HI_END = PW'(2*CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t            state, state_d;
  logic [WIDTH-1:0]  cap, cap_d, shreg, shreg_d, sent_d;
  logic [BW-1:0]     bit_cnt, bit_d;
  logic [PW-1:0]     phase, ph_d;
  logic              sclk_d, sdata_d, latch_d, busy_d, pending, pend_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cap       <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      phase     <= '0;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      latch     <= 1'b0;
      busy      <= 1'b0;
      sent_word <= '0;
      pending   <= 1'b1;
    end else begin
      state     <= state_d;
      cap       <= cap_d;
      shreg     <= shreg_d;
      bit_cnt   <= bit_d;
      phase     <= ph_d;
      sclk      <= sclk_d;
      sdata     <= sdata_d;
      latch     <= latch_d;
      busy      <= busy_d;
      sent_word <= sent_d;
      pending   <= pend_d;
    end
  end

  always_comb begin
    state_d = state;
    cap_d   = cap;
    shreg_d = shreg;
    bit_d   = bit_cnt;
    ph_d    = phase;
    sclk_d  = sclk;
    sdata_d = sdata;
    latch_d = latch;
    busy_d  = busy;
    sent_d  = sent_word;
    pend_d  = pending;
    case (state)
      IDLE: begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        latch_d = 1'b0;
        busy_d  = 1'b0;
        // force_update is only sampled here, so pulses during a transfer drop
        if (pending || force_update || (in_word != sent_word)) begin
          cap_d   = in_word;
          shreg_d = in_word;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
          sdata_d = in_word[WIDTH-1];
          bit_d   = '0;
          ph_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (phase == PH_HI_END) begin
          ph_d   = '0;
          sclk_d = 1'b0;
          if (bit_cnt == LAST_BIT) begin
            sdata_d = 1'b0;
            latch_d = 1'b1;
            state_d = LATCH;
          end else begin
            bit_d   = bit_cnt + 1'b1;
            shreg_d = {shreg[WIDTH-2:0], 1'b0};
            sdata_d = shreg[WIDTH-2];
          end
        end else begin
          ph_d = phase + 1'b1;
          if (phase == PH_LO_END) sclk_d = 1'b1;
        end
      end
      LATCH: begin
        if (phase == PH_LO_END) begin
          latch_d = 1'b0;
          busy_d  = 1'b0;
          sent_d  = cap;
          ph_d    = '0;
          state_d = IDLE;
        end else begin
          ph_d = phase + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pio_word_serializer.sv
// Directed bench: default build plus a CLK_DIV=1 build, each observed through
// a behavioural 595 model clocked by sclk and latched by the latch strobe.
module tb_pio_word_serializer;
  localparam int W = 18;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [W-1:0] in_word = '0, in_word1 = '0;
  logic force_update = 1'b0;
  logic sclk, sdata, latch, busy, sclk1, sdata1, latch1, busy1;
  logic [W-1:0] sent_word, sent_word1;

  int checks = 0, errors = 0;
  int sclk_rises = 0, latch_pulses = 0;
  logic [W-1:0] m_sr = '0, m_q = '0, m1_sr = '0, m1_q = '0;

  always #5 clk = ~clk;

  pio_word_serializer #(.WIDTH(W), .CLK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_word(in_word), .force_update(force_update),
    .sclk(sclk), .sdata(sdata), .latch(latch), .busy(busy), .sent_word(sent_word));

  pio_word_serializer #(.WIDTH(W), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_word(in_word1), .force_update(1'b0),
    .sclk(sclk1), .sdata(sdata1), .latch(latch1), .busy(busy1), .sent_word(sent_word1));

  always @(posedge sclk) begin m_sr <= {m_sr[W-2:0], sdata}; sclk_rises++; end
  always @(posedge latch) begin m_q <= m_sr; latch_pulses++; end
  always @(posedge sclk1) m1_sr <= {m1_sr[W-2:0], sdata1};
  always @(posedge latch1) m1_q <= m1_sr;

  // Called at a negedge; waits for busy, then counts busy-high negedges.
  task automatic run_transfer(output int dur, output int lat_w);
    dur = 0; lat_w = 0;
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    while (busy && dur < 500) begin
      dur++;
      if (latch) lat_w++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int dur, lw, lp0;
    #2;
    checks++;
    if ({sclk, sdata, latch, busy} !== 4'b0 || sent_word !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b/%h want 0000/0", {sclk, sdata, latch, busy}, sent_word);
    end
    @(negedge clk); reset_n = 1'b1;
    lp0 = latch_pulses;
    m_sr = '1;
    run_transfer(dur, lw);
    checks++;
    if (dur !== 148) begin errors++; $display("FAIL reset_busy_len: got %0d want 148", dur); end
    checks++;
    if (lw !== 4 || latch_pulses - lp0 !== 1) begin
      errors++; $display("FAIL reset_latch: width %0d pulses %0d want 4/1", lw, latch_pulses - lp0);
    end
    checks++;
    if (m_q !== '0 || sent_word !== '0) begin
      errors++; $display("FAIL reset_word: model %h sent %h want 0/0", m_q, sent_word);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || latch_pulses - lp0 !== 1) begin
      errors++; $display("FAIL reset_no_second: busy %b pulses %0d want 0/1", busy, latch_pulses - lp0);
    end
  endtask

  task automatic test_word();
    int dur, lw;
    in_word = 18'h2A5C3;
    run_transfer(dur, lw);
    checks++;
    if (dur !== 148) begin errors++; $display("FAIL word_busy_len: got %0d want 148", dur); end
    checks++;
    if (m_q !== 18'h2A5C3) begin errors++; $display("FAIL word_model: got %h want 2a5c3", m_q); end
    checks++;
    if (sent_word !== 18'h2A5C3) begin errors++; $display("FAIL word_sent: got %h want 2a5c3", sent_word); end
  endtask

  task automatic test_hold_force();
    int r0, bsy, dur, lw, lp0;
    r0 = sclk_rises; bsy = 0;
    repeat (1000) begin @(negedge clk); if (busy) bsy++; end
    checks++;
    if (bsy !== 0 || sclk_rises !== r0) begin
      errors++; $display("FAIL hold_idle: busy cycles %0d sclk rises %0d want 0/0", bsy, sclk_rises - r0);
    end
    lp0 = latch_pulses; m_sr = '0;
    force_update = 1'b1;
    @(negedge clk); force_update = 1'b0;
    run_transfer(dur, lw);
    repeat (40) @(negedge clk);
    checks++;
    if (dur !== 148 || latch_pulses - lp0 !== 1 || sclk_rises - r0 !== 18) begin
      errors++; $display("FAIL force_once: dur %0d pulses %0d rises %0d want 148/1/18", dur, latch_pulses - lp0, sclk_rises - r0);
    end
    checks++;
    if (m_q !== 18'h2A5C3) begin errors++; $display("FAIL force_model: got %h want 2a5c3", m_q); end
  endtask

  task automatic test_back_to_back();
    int n, idle, dur, lw;
    in_word = 18'h3FFFF;
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    n = 0;
    while (busy && n < 500) begin
      n++;
      if (n == 50) in_word = 18'h00001;
      @(negedge clk);
    end
    checks++;
    if (m_q !== 18'h3FFFF || sent_word !== 18'h3FFFF || n !== 148) begin
      errors++; $display("FAIL b2b_first: model %h sent %h dur %0d want 3ffff/3ffff/148", m_q, sent_word, n);
    end
    idle = 0;
    while (!busy && idle < 50) begin idle++; @(negedge clk); end
    checks++;
    if (idle !== 1) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want 1", idle); end
    run_transfer(dur, lw);
    checks++;
    if (m_q !== 18'h00001 || sent_word !== 18'h00001) begin
      errors++; $display("FAIL b2b_second: model %h sent %h want 00001", m_q, sent_word);
    end
  endtask

  task automatic test_reset_mid();
    int dur, lw;
    in_word = 18'h12345;
    for (int i = 0; i < 50 && !busy; i++) @(negedge clk);
    repeat (9*8 + 2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({sclk, sdata, latch, busy} !== 4'b0 || sent_word !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %b/%h want 0000/0", {sclk, sdata, latch, busy}, sent_word);
    end
    @(negedge clk); reset_n = 1'b1;
    run_transfer(dur, lw);
    checks++;
    if (dur !== 148 || m_q !== 18'h12345 || sent_word !== 18'h12345) begin
      errors++; $display("FAIL midreset_resend: dur %0d model %h sent %h want 148/12345", dur, m_q, sent_word);
    end
  endtask

  task automatic test_div1();
    int n, bad;
    repeat (60) @(negedge clk);
    in_word1 = 18'h15555;
    for (int i = 0; i < 50 && !busy1; i++) @(negedge clk);
    n = 0; bad = 0;
    while (busy1 && n < 200) begin
      if (n < 36 && sclk1 !== n[0]) bad++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 37) begin errors++; $display("FAIL div1_busy_len: got %0d want 37", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL div1_sclk_toggle: %0d bad samples want 0", bad); end
    checks++;
    if (m1_q !== 18'h15555 || sent_word1 !== 18'h15555) begin
      errors++; $display("FAIL div1_model: model %h sent %h want 15555", m1_q, sent_word1);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_hold_force();
    test_back_to_back();
    test_reset_mid();
    test_div1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
